// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Holds the controller state enum, the zero register id and default latency.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hc_state_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_LAT_DEFAULT = 4;

endpackage

// File: rtl/md_latency_counter.sv
// Loadable down-counter tracking the remaining EX cycles of a mult/div op.
// Ports: clk, rst, load_i, load_val_i, en_i -> zero_o, value_o.
module md_latency_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o,
  output logic [CNT_W-1:0] value_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o  = (cnt_q == '0);
  assign value_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, mult/div freeze.
// Ports: hazard inputs from ID/EX -> PC/IF/ID/ID/EX/EX/MEM enables and bubbles.
// Optional HAZARD_PERF_EN adds stall_cycles and flush_count perf counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT,
  parameter int CNT_W  = $clog2(MD_LAT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       branch_taken,
  input  logic       md_start,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_write,
  output logic       idex_bubble,
  output logic       exmem_bubble,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  hc_state_t state_q;
  hc_state_t state_d;

  logic             lu;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             unused_cnt;

  assign unused_cnt = ^cnt_val;

  assign lu = ex_memread
            & (ex_rt != REG_ZERO)
            & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  md_latency_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(CNT_W'(MD_LAT - 2)),
    .en_i      (cnt_en),
    .zero_o    (cnt_zero),
    .value_o   (cnt_val)
  );

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (md_start) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            md_busy      = 1'b1;
            cnt_load     = 1'b1;
            state_d      = MD_BUSY;
          end else if (lu) begin
            // bubble clears ex_memread next cycle, so stall is 1 cycle
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MD_BUSY: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_bubble = 1'b1;
          md_busy      = 1'b1;
          if (cnt_zero) begin
            // last busy cycle: result passes on to MEM
            md_done      = 1'b1;
            exmem_bubble = 1'b0;
            state_d      = RUN;
          end else begin
            cnt_en = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (ifid_flush && (flush_q != '1)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a cycle-count reference model.
// Output vector order: pc, ifid_w, ifid_flush, idex_w, idex_bub, exmem_bub, busy, done.
module tb_hazard_ctrl;

  localparam int MD_LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_uses_rt = 1'b0;
  logic       ex_memread = 1'b0;
  logic [4:0] ex_rt = '0;
  logic       branch_taken = 1'b0;
  logic       md_start = 1'b0;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_bubble;
  logic       exmem_bubble;
  logic       md_busy;
  logic       md_done;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  logic [7:0] obs;
  int vecs = 0;
  int errs = 0;
  int rem  = 0;

  localparam logic [7:0] V_RST   = 8'b0000_1000;
  localparam logic [7:0] V_RUN   = 8'b1101_0000;
  localparam logic [7:0] V_LU    = 8'b0001_1000;
  localparam logic [7:0] V_BR    = 8'b1111_1000;
  localparam logic [7:0] V_MD    = 8'b0000_0110;
  localparam logic [7:0] V_MDEND = 8'b0000_0011;

  assign obs = {pc_write, ifid_write, ifid_flush, idex_write,
                idex_bubble, exmem_bubble, md_busy, md_done};

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MD_LAT(MD_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_memread  (ex_memread),
    .ex_rt       (ex_rt),
    .branch_taken(branch_taken),
    .md_start    (md_start),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_write  (idex_write),
    .idex_bubble (idex_bubble),
    .exmem_bubble(exmem_bubble),
    .md_busy     (md_busy),
    .md_done     (md_done)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  // Reference: rem = EX cycles still owed to an in-flight mult/div op.
  function automatic logic [7:0] model_out(int r, logic lu, logic br,
                                           logic md);
    if (r > 0) return (r == 1) ? V_MDEND : V_MD;
    if (br) return V_BR;
    if (md) return V_MD;
    if (lu) return V_LU;
    return V_RUN;
  endfunction

  function automatic logic ref_lu();
    return ex_memread && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses, input logic mr,
                        input logic [4:0] exrt, input logic br,
                        input logic md);
    id_rs = rs;
    id_rt = rt;
    id_uses_rt = uses;
    ex_memread = mr;
    ex_rt = exrt;
    branch_taken = br;
    md_start = md;
  endtask

  task automatic step();
    if (rem > 0) rem = rem - 1;
    else if (!branch_taken && md_start) rem = MD_LAT - 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vecs++;
    if (obs !== V_RST) begin
      errs++;
      $display("FAIL reset obs=%b exp=%b", obs, V_RST);
    end
    rst = 1'b0;
    rem = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_no_hazard();
    for (int i = 0; i < 6; i++) begin
      set_in(5'($urandom), 5'($urandom), 1'($urandom), 1'b0,
             5'($urandom), 1'b0, 1'b0);
      @(negedge clk);
      vecs++;
      if (obs !== V_RUN) begin
        errs++;
        $display("FAIL no_hazard[%0d] obs=%b exp=%b", i, obs, V_RUN);
      end
      step();
    end
  endtask

  task automatic test_load_use();
    set_in(5'd8, 5'd3, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    @(negedge clk);
    vecs++;
    if (obs !== V_LU) begin
      errs++;
      $display("FAIL lu_rs obs=%b exp=%b", obs, V_LU);
    end
    step();
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    vecs++;
    if (obs !== V_RUN) begin
      errs++;
      $display("FAIL lu_r0 obs=%b exp=%b", obs, V_RUN);
    end
    step();
    set_in(5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    @(negedge clk);
    vecs++;
    if (obs !== V_RUN) begin
      errs++;
      $display("FAIL lu_rt_unused obs=%b exp=%b", obs, V_RUN);
    end
    step();
    set_in(5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    @(negedge clk);
    vecs++;
    if (obs !== V_LU) begin
      errs++;
      $display("FAIL lu_rt obs=%b exp=%b", obs, V_LU);
    end
    step();
  endtask

  task automatic test_branch();
    set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    @(negedge clk);
    vecs++;
    if (obs !== V_BR) begin
      errs++;
      $display("FAIL branch_lu obs=%b exp=%b", obs, V_BR);
    end
    step();
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    @(negedge clk);
    vecs++;
    if (obs !== V_BR) begin
      errs++;
      $display("FAIL branch_md obs=%b exp=%b", obs, V_BR);
    end
    step();
  endtask

  task automatic test_md();
    logic [7:0] exp;
    for (int c = 1; c <= MD_LAT + 1; c++) begin
      set_in(5'd8, 5'd8, 1'b1, (c == 2), 5'd8, (c == 2), (c == 1));
      if (c < MD_LAT) exp = V_MD;
      else if (c == MD_LAT) exp = V_MDEND;
      else exp = V_RUN;
      @(negedge clk);
      vecs++;
      if (obs !== exp) begin
        errs++;
        $display("FAIL md_cycle%0d obs=%b exp=%b", c, obs, exp);
      end
      step();
    end
  endtask

  task automatic test_md_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    #1 rst = 1'b1;
    #1;
    vecs++;
    if (obs !== V_RST) begin
      errs++;
      $display("FAIL md_async_rst obs=%b exp=%b", obs, V_RST);
    end
    rem = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < MD_LAT + 2; i++) begin
      @(negedge clk);
      vecs++;
      if (obs !== V_RUN) begin
        errs++;
        $display("FAIL md_abort[%0d] obs=%b exp=%b", i, obs, V_RUN);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    for (int i = 0; i < 400; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 11) == 0));
      exp = model_out(rem, ref_lu(), branch_taken, md_start);
      @(negedge clk);
      vecs++;
      if (obs !== exp) begin
        errs++;
        $display("FAIL random[%0d] obs=%b exp=%b", i, obs, exp);
      end
      step();
    end
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < MD_LAT && rem > 0; i++) step();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    #2 rst = 1'b0;
    rem = 0;
    @(posedge clk);
    #1;
    set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    step();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 1; i < MD_LAT; i++) step();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    vecs++;
    if (stall_cycles !== 32'(MD_LAT + 1)) begin
      errs++;
      $display("FAIL perf_stall got=%0d exp=%0d", stall_cycles, MD_LAT + 1);
    end
    vecs++;
    if (flush_count !== 16'd1) begin
      errs++;
      $display("FAIL perf_flush got=%0d exp=1", flush_count);
    end
    step();
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_no_hazard();
    test_load_use();
    test_branch();
    test_md();
    test_md_reset();
    test_random();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
